// File: rtl/lsu_ctrl.sv
// Load/store sequencer: decodes core accesses, drives a handshaked memory bus, formats lanes.
// Latency: 3 cycles minimum (IDLE, WAIT with ack, DONE); one extra cycle per WAIT without ack.
// Backpressure: holds stall while mem_ack is awaited; aborts with bus_err after TIMEOUT WAIT cycles.
module lsu_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        load_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              load_valid_q, load_valid_d;
    logic              bus_err_q, bus_err_d;

    logic        access;
    logic        legal_f3;
    logic        aligned;
    logic        acc_ok;
    logic [1:0]  size;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_val;
    logic        timeout_hit;

    assign access = rd_en | wr_en;

    // Unsigned loads (100/101) have no store counterpart, so they are legal only with rd_en.
    always_comb begin
        legal_f3 = 1'b0;
        size     = 2'd0;
        case (func3)
            3'b000: begin legal_f3 = 1'b1;  size = 2'd0; end
            3'b001: begin legal_f3 = 1'b1;  size = 2'd1; end
            3'b010: begin legal_f3 = 1'b1;  size = 2'd2; end
            3'b100: begin legal_f3 = rd_en; size = 2'd0; end
            3'b101: begin legal_f3 = rd_en; size = 2'd1; end
            default: begin legal_f3 = 1'b0; size = 2'd0; end
        endcase
    end

    always_comb begin
        aligned   = 1'b1;
        be_dec    = 4'b0001 << addr[1:0];
        wdata_dec = {4{wdata[7:0]}};
        case (size)
            2'd1: begin
                aligned   = ~addr[0];
                be_dec    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{wdata[15:0]}};
            end
            2'd2: begin
                aligned   = (addr[1:0] == 2'b00);
                be_dec    = 4'b1111;
                wdata_dec = wdata;
            end
            default: begin
                aligned   = 1'b1;
                be_dec    = 4'b0001 << addr[1:0];
                wdata_dec = {4{wdata[7:0]}};
            end
        endcase
    end

    assign acc_ok   = access & legal_f3 & aligned;
    assign misalign = rst_n & (state_q == S_IDLE) & access & ~(legal_f3 & aligned);
    assign stall    = rst_n & (((state_q == S_IDLE) & acc_ok) | (state_q == S_WAIT));

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (off_q)
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ld_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  ld_val = {24'd0, byte_sel};
            3'b101:  ld_val = {16'd0, half_sel};
            default: ld_val = mem_rdata;
        endcase
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        off_d        = off_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc_ok) begin
                    state_d     = S_WAIT;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~rd_en;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_be_d    = be_dec;
                    mem_wdata_d = wdata_dec;
                    f3_d        = func3;
                    off_d       = addr[1:0];
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        load_valid_d = 1'b1;
                        rdata_d      = ld_val;
                    end
                end else if (timeout_hit) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Core retires here; any rd_en/wr_en still held belongs to the retiring instruction.
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign rdata      = rdata_q;
    assign load_valid = load_valid_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus random accesses checked against a transaction-level model.
module tb_lsu_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, load_valid, misalign, bus_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .func3(func3),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .load_valid(load_valid), .misalign(misalign), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Reference: access width in bytes, lane offset and extension computed arithmetically.
    function automatic void model(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] word,
                                  output bit legal, output logic [3:0] be,
                                  output logic [31:0] wexp, output logic [31:0] rexp);
        int nb;
        bit sgn;
        logic [31:0] sh, mask;
        legal = 1'b1; nb = 1; sgn = 1'b0;
        case (f3)
            3'd0: begin nb = 1; sgn = 1'b1; end
            3'd1: begin nb = 2; sgn = 1'b1; end
            3'd2: nb = 4;
            3'd4: begin nb = 1; legal = rd; end
            3'd5: begin nb = 2; legal = rd; end
            default: legal = 1'b0;
        endcase
        if ((int'(a[1:0]) % nb) != 0) legal = 1'b0;
        be = 4'(((1 << nb) - 1) << a[1:0]);
        wexp = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
        sh = word >> (8 * a[1:0]);
        mask = (nb == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        if (nb == 4) rexp = word;
        else begin
            rexp = sh & mask;
            if (sgn && sh[8*nb-1]) rexp = rexp | ~mask;
        end
    endfunction

    // ack_k: WAIT cycle carrying mem_ack (outside 1..TO means never). tail: idle cycle with a stray ack afterwards.
    task automatic run_access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                              input int ack_k, input bit tail);
        bit legal, tmo;
        logic [3:0] be;
        logic [31:0] wexp, rexp;
        int stalls;
        model(rd, f3, a, wd, word, legal, be, wexp, rexp);
        tmo = (ack_k < 1) || (ack_k > TO);
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; func3 = f3; addr = a; wdata = wd; mem_ack = 1'b0;
        @(negedge clk);
        total++; if (stall !== legal) begin bad++; $display("FAIL %s idle_stall got=%0b exp=%0b", nm, stall, legal); end
        total++; if (misalign !== !legal) begin bad++; $display("FAIL %s misalign got=%0b exp=%0b", nm, misalign, !legal); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL %s idle_req got=%0b exp=0", nm, mem_req); end
        if (!legal) begin
            @(posedge clk); #1;
            rd_en = 1'b0; wr_en = 1'b0;
            @(negedge clk);
            total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin
                bad++; $display("FAIL %s trap_no_req got req=%0b stall=%0b exp 0 0", nm, mem_req, stall); end
            return;
        end
        stalls = (stall === 1'b1) ? 1 : 0;
        for (int c = 1; c <= TO; c++) begin
            @(posedge clk); #1;
            addr = $urandom; wdata = $urandom;
            mem_ack = (c == ack_k);
            mem_rdata = (c == ack_k) ? word : $urandom;
            @(negedge clk);
            if (stall === 1'b1) stalls++;
            total++; if (mem_req !== 1'b1 || mem_addr !== {a[31:2], 2'b00} || mem_be !== be || mem_we !== !rd) begin
                bad++; $display("FAIL %s wait%0d bus got req=%0b addr=%h be=%b we=%0b exp 1 %h %b %0b",
                                nm, c, mem_req, mem_addr, mem_be, mem_we, {a[31:2], 2'b00}, be, !rd); end
            if (!rd) begin
                total++; if (mem_wdata !== wexp) begin
                    bad++; $display("FAIL %s wait%0d wdata got=%h exp=%h", nm, c, mem_wdata, wexp); end
            end
            if (c == ack_k) break;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL %s done_idle got stall=%0b req=%0b exp 0 0", nm, stall, mem_req); end
        total++; if (load_valid !== (rd && !tmo) || bus_err !== tmo) begin
            bad++; $display("FAIL %s done_flags got lv=%0b err=%0b exp %0b %0b", nm, load_valid, bus_err, rd && !tmo, tmo); end
        if (rd || tmo) begin
            total++; if (rdata !== (tmo ? 32'h0 : rexp)) begin
                bad++; $display("FAIL %s rdata got=%h exp=%h", nm, rdata, tmo ? 32'h0 : rexp); end
        end
        total++; if (stalls !== (tmo ? TO + 1 : ack_k + 1)) begin
            bad++; $display("FAIL %s stall_cycles got=%0d exp=%0d", nm, stalls, tmo ? TO + 1 : ack_k + 1); end
        if (tail) begin
            @(posedge clk); #1;
            rd_en = 1'b0; wr_en = 1'b0; mem_ack = 1'b1;
            @(negedge clk);
            total++; if (mem_req !== 1'b0 || stall !== 1'b0 || load_valid !== 1'b0 || bus_err !== 1'b0) begin
                bad++; $display("FAIL %s after_done got req=%0b stall=%0b lv=%0b err=%0b exp 0 0 0 0",
                                nm, mem_req, stall, load_valid, bus_err); end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            @(negedge clk);
            total++; if (load_valid !== 1'b0 || mem_req !== 1'b0) begin
                bad++; $display("FAIL %s stray_ack got lv=%0b req=%0b exp 0 0", nm, load_valid, mem_req); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd_en = 1'b1; func3 = 3'd3; addr = 32'h1;
        #12;
        total++; if (stall !== 1'b0 || misalign !== 1'b0) begin
            bad++; $display("FAIL reset_comb got stall=%0b mis=%0b exp 0 0", stall, misalign); end
        total++; if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_be !== 0 || mem_wdata !== 0 ||
                     rdata !== 0 || load_valid !== 0 || bus_err !== 0) begin
            bad++; $display("FAIL reset_regs got req=%0b we=%0b addr=%h be=%b wd=%h rd=%h lv=%0b err=%0b exp all 0",
                            mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata, load_valid, bus_err); end
        rd_en = 1'b0; func3 = 3'd0; addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        run_access("lw", 1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1);
        run_access("lb", 1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 2, 0);
        run_access("lbu", 1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 1, 1);
    endtask

    task automatic test_store();
        run_access("sh", 0, 1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 3, 1);
    endtask

    task automatic test_misalign();
        run_access("lw_mis", 1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 1, 1);
        run_access("lh_ill", 1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 1, 1);
        run_access("sbu_ill", 0, 1, 3'd4, 32'h100, 32'h0, 32'h0, 1, 1);
    endtask

    task automatic test_timeout();
        run_access("sw_to", 0, 1, 3'd2, 32'h300, 32'h12345678, 32'h0, 0, 1);
        run_access("lw_to", 1, 0, 3'd2, 32'h304, 32'h0, 32'hFFFFFFFF, 0, 1);
    endtask

    task automatic test_back_to_back();
        run_access("both_rd", 1, 1, 3'd1, 32'h102, 32'h5555AAAA, 32'h9876FEDC, 2, 0);
        run_access("b2b_sw", 0, 1, 3'd2, 32'h40, 32'hCAFEF00D, 32'h0, 1, 0);
        run_access("b2b_lhu", 1, 0, 3'd5, 32'h46, 32'h0, 32'h8001_7FFF, TO, 1);
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        rd_en = 1'b1; wr_en = 1'b0; func3 = 3'd2; addr = 32'h500;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL midrst_pre got req=%0b exp 1", mem_req); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (mem_req !== 0 || stall !== 0 || mem_addr !== 0 || mem_be !== 0 || load_valid !== 0 || bus_err !== 0) begin
            bad++; $display("FAIL midrst_async got req=%0b stall=%0b addr=%h be=%b lv=%0b err=%0b exp all 0",
                            mem_req, stall, mem_addr, mem_be, load_valid, bus_err); end
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_access("lw_after_rst", 1, 0, 3'd2, 32'h504, 32'h0, 32'h13579BDF, 2, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic rd, wr;
            int sel;
            sel = $urandom_range(0, 3);
            rd = (sel != 1);
            wr = (sel == 1) || (sel == 2);
            run_access($sformatf("rnd%0d", i), rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                       $urandom_range(1, TO + 1), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store sequencer between the single-cycle core's control/ALU outputs and a handshaked data-memory bus. The block takes `rd_en`/`wr_en`, `func3`, the ALU-computed address and the rs2 store data. It stalls the core while the bus transaction is outstanding, and formats the byte lanes and the sign/zero extension. It also flags misaligned or illegal accesses and bus timeouts.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of WAIT cycles without `mem_ack` before the access is aborted. Legal range is 1..65535.
- `CNT_W`, default 16: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in, 1: rising-edge clock.
  - `rst_n` in, 1: asynchronous active-low reset.
- Inputs from the core:
  - `rd_en` in, 1: load instruction present.
  - `wr_en` in, 1: store instruction present.
  - `func3` in, 3: access size/sign code from instruction bits [14:12].
  - `addr` in, 32: byte address from the ALU.
  - `wdata` in, 32: store data (rs2).
- Outputs to the core:
  - `stall` out, 1: hold PC and suppress register write.
  - `rdata` out, 32: extended load result, valid when `load_valid`=1.
  - `load_valid` out, 1: one-cycle strobe; the core writes `rdata` back this cycle.
  - `misalign` out, 1: combinational; misaligned address or illegal `func3`.
  - `bus_err` out, 1: one-cycle strobe; the access timed out.
- Memory bus:
  - `mem_req` out, 1: bus request.
  - `mem_we` out, 1: 1 for a store, 0 for a load.
  - `mem_addr` out, 32: word-aligned address, equal to {addr[31:2], 2'b00}.
  - `mem_be` out, 4: byte enables.
  - `mem_wdata` out, 32: lane-replicated store data.
  - `mem_ack` in, 1: the memory completes the request this cycle.
  - `mem_rdata` in, 32: word read data, valid together with `mem_ack`.

## Operation
- Access decode:
  - `rd_en` has priority over `wr_en` when both are set.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other `func3` code is illegal.
- Alignment rules:
  - Halfword accesses need addr[0]=0.
  - Word accesses need addr[1:0]=00.
  - A violation or an illegal `func3` gives `misalign`=1 (combinational, IDLE only) and `stall`=0. No bus request is issued; the core handles the trap.
- Byte enables:
  - Byte: `mem_be` = 1 << addr[1:0].
  - Half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - Word: 1111.
  - Byte stores replicate wdata[7:0] into all 4 lanes. Half stores replicate wdata[15:0] into both halves. Word stores pass wdata unchanged.
- Load extraction:
  - Select the lane from `mem_rdata` using the captured addr[1:0].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU; LW passes the word through.
  - The result is registered into `rdata` on the `mem_ack` edge.
- State machine: IDLE, WAIT, DONE.
  - IDLE: on a legal access (`rd_en`|`wr_en`), `stall`=1 combinationally. Capture the address, byte enables, write data, `func3` and direction, then go to WAIT.
  - WAIT: `mem_req`=1 and `stall`=1. `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` stay constant until ack.
    - On `mem_ack`: go to DONE.
    - On the counter reaching TIMEOUT-1 without ack: go to DONE with the error flag set.
    - Otherwise the counter increments.
  - DONE: `stall`=0, `mem_req`=0.
    - `load_valid`=1 for a load without error.
    - `bus_err`=1 if timed out; `rdata` is 0 on error.
    - Unconditionally go to IDLE. The `rd_en`/`wr_en` still asserted in DONE are ignored, because the core retires the instruction at this edge.
- `mem_ack` while `mem_req`=0 is ignored.
- The counter clears on entry to WAIT.

## Timing
- Reset values: state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_be` 0, `mem_wdata` 0, `rdata` 0, `load_valid` 0, `bus_err` 0, counter 0.
- `stall` and `misalign` are 0 while `rst_n`=0.
- Assertion of `rst_n` mid-transaction forces IDLE immediately and drops `mem_req` asynchronously. The abandoned transaction is not retried.
- Minimum occupancy is 3 cycles: IDLE (stall), WAIT with ack in the same cycle (stall), DONE (retire). This gives 2 stall cycles.
- With ack in the k-th WAIT cycle, the core sees k+1 stall cycles.
- On timeout, WAIT lasts exactly TIMEOUT cycles, followed by DONE with `bus_err`.
- Back-to-back accesses: the next instruction can be seen in IDLE on the cycle after DONE.

## Test plan
- LW at addr 0x100, `mem_rdata`=0xDEADBEEF, ack on the 1st WAIT cycle -> `mem_be`=1111, `mem_addr`=0x100, `stall` high for 2 cycles, DONE `load_valid`=1, `rdata`=0xDEADBEEF.
- LB at 0x103 and LBU at 0x103, `mem_rdata`=0x80FF1234 -> `mem_be`=1000; LB `rdata`=0xFFFFFF80, LBU `rdata`=0x00000080.
- SH at 0x202, `wdata`=0x0000ABCD, ack delayed 3 cycles -> `mem_be`=1100, `mem_wdata`=0xABCDABCD held stable for 3 WAIT cycles, `mem_we`=1, `stall` high for 4 cycles, `load_valid`=0.
- LW at 0x101; also LH with `func3`=011 -> `misalign`=1, `stall`=0, `mem_req` never asserted.
- With TIMEOUT=4, SW and no ack -> `mem_req` high for exactly 4 cycles, then DONE `bus_err`=1 for 1 cycle, `stall`=0, state returns to IDLE.
- `rst_n` pulled low in the 2nd WAIT cycle -> `mem_req`, `stall` and all outputs go to reset values immediately; after release a new LW completes normally.
